sdram_port_arbiter: RTL and testbench

- Parametrised SDRAM front-end for board tops. Sits between NCH Wishbone-style masters (CPU, DMA, video) and one req/ack SDRAM controller (separate wr/rd request, pulsed acks, init_done).
- Performs round-robin arbitration, latches address, data and byte masks, and generates level replies held until strobe release.
- Also generates the controller's delayed reset release.

---
 rtl/sdram_port_arbiter.sv | 167 ++++++++++++++++
 tb/tb_sdram_port_arbiter.sv | 268 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/sdram_port_arbiter.sv
// Round-robin front-end joining NCH Wishbone-style masters to one req/ack SDRAM controller,
// including the controller's delayed reset release.
module sdram_port_arbiter #(
  parameter int NCH     = 2,
  parameter int AW      = 21,
  parameter int DW      = 16,
  parameter int RST_DLY = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [NCH-1:0]        wb_stb,
  input  logic [NCH-1:0]        wb_we,
  input  logic [NCH*DW/8-1:0]   wb_sel,
  input  logic [NCH*AW-1:0]     wb_adr,
  input  logic [NCH*DW-1:0]     wb_wdat,
  output logic [NCH-1:0]        wb_ack,
  output logic [DW-1:0]         wb_rdat,
  output logic                  mem_rst_n,
  input  logic                  mem_ready,
  output logic                  mem_wr_req,
  output logic                  mem_rd_req,
  input  logic                  mem_wr_ack,
  input  logic                  mem_rd_ack,
  output logic [AW-1:0]         mem_adr,
  output logic [DW-1:0]         mem_wdat,
  output logic [DW/8-1:0]       mem_dqm,
  input  logic [DW-1:0]         mem_rdat,
  output logic [1:0]            dbg_state
);

  localparam int BW = DW / 8;
  localparam int GW = (NCH > 1) ? $clog2(NCH) : 1;
  localparam int CW = $clog2(RST_DLY + 1);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_REQ   = 2'd1;
  localparam logic [1:0] S_HOLD  = 2'd2;
  localparam logic [1:0] S_DRAIN = 2'd3;

  logic [1:0]    state;
  logic [GW-1:0] last_grant;
  logic [GW-1:0] grant;
  logic [GW-1:0] pick;
  logic          pick_any;
  logic          cur_we;
  logic          reply;
  logic          aborted;
  logic [CW-1:0] dly_cnt;

  logic          p_we;
  logic [BW-1:0] p_sel;
  logic [AW-1:0] p_adr;
  logic [DW-1:0] p_wdat;
  logic          g_stb;
  logic          ack_hit;

  assign dbg_state = state;
  assign ack_hit   = cur_we ? mem_wr_ack : mem_rd_ack;

  // Controller reset is released RST_DLY cycles after the first cycle with rst_n high.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      dly_cnt   <= '0;
      mem_rst_n <= 1'b0;
    end else if (!mem_rst_n) begin
      dly_cnt <= dly_cnt + 1'b1;
      if (dly_cnt == CW'(RST_DLY - 1)) mem_rst_n <= 1'b1;
    end
  end

  // Search starts just after the previous winner, wrapping modulo NCH.
  always_comb begin
    pick     = last_grant;
    pick_any = 1'b0;
    for (int k = 1; k <= NCH; k++) begin
      if (!pick_any && wb_stb[(int'(last_grant) + k) % NCH]) begin
        pick     = GW'((int'(last_grant) + k) % NCH);
        pick_any = 1'b1;
      end
    end
  end

  always_comb begin
    p_we   = 1'b0;
    p_sel  = '0;
    p_adr  = '0;
    p_wdat = '0;
    g_stb  = 1'b0;
    for (int i = 0; i < NCH; i++) begin
      if (GW'(i) == pick) begin
        p_we   = wb_we[i];
        p_sel  = wb_sel[i*BW +: BW];
        p_adr  = wb_adr[i*AW +: AW];
        p_wdat = wb_wdat[i*DW +: DW];
      end
      if (GW'(i) == grant) g_stb = wb_stb[i];
    end
  end

  // The reply is qualified by the live strobe so the ack falls in the same cycle as the strobe.
  always_comb begin
    wb_ack = '0;
    for (int i = 0; i < NCH; i++) begin
      wb_ack[i] = reply & g_stb & (GW'(i) == grant);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state      <= S_IDLE;
      last_grant <= GW'(NCH - 1);
      grant      <= '0;
      cur_we     <= 1'b0;
      reply      <= 1'b0;
      aborted    <= 1'b0;
      mem_wr_req <= 1'b0;
      mem_rd_req <= 1'b0;
      wb_rdat    <= '0;
      mem_adr    <= '0;
      mem_wdat   <= '0;
      mem_dqm    <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (mem_ready && pick_any) begin
            grant      <= pick;
            cur_we     <= p_we;
            aborted    <= 1'b0;
            mem_adr    <= p_adr;
            mem_wdat   <= p_wdat;
            mem_dqm    <= p_we ? ~p_sel : '0;
            mem_wr_req <= p_we;
            mem_rd_req <= ~p_we;
            state      <= S_REQ;
          end
        end
        S_REQ: begin
          // The controller cannot be cancelled, so an abort still waits for the ack.
          if (!g_stb) aborted <= 1'b1;
          if (ack_hit) begin
            mem_wr_req <= 1'b0;
            mem_rd_req <= 1'b0;
            if (!cur_we) wb_rdat <= mem_rdat;
            if (g_stb && !aborted) begin
              reply <= 1'b1;
              state <= S_HOLD;
            end else begin
              state <= S_DRAIN;
            end
          end
        end
        S_HOLD: begin
          if (!g_stb) begin
            reply      <= 1'b0;
            last_grant <= grant;
            state      <= S_IDLE;
          end
        end
        default: begin
          last_grant <= grant;
          state      <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_sdram_port_arbiter.sv
// Directed bench for sdram_port_arbiter with three masters and a hand-driven controller.
module tb_sdram_port_arbiter;

  localparam int NCH     = 3;
  localparam int AW      = 21;
  localparam int DW      = 16;
  localparam int BW      = DW / 8;
  localparam int RST_DLY = 4;
  localparam int W       = 1 + AW + DW + BW;

  logic              clk;
  logic              rst_n;
  logic [NCH-1:0]    wb_stb;
  logic [NCH-1:0]    wb_we;
  logic [NCH*BW-1:0] wb_sel;
  logic [NCH*AW-1:0] wb_adr;
  logic [NCH*DW-1:0] wb_wdat;
  logic [NCH-1:0]    wb_ack;
  logic [DW-1:0]     wb_rdat;
  logic              mem_rst_n;
  logic              mem_ready;
  logic              mem_wr_req;
  logic              mem_rd_req;
  logic              mem_wr_ack;
  logic              mem_rd_ack;
  logic [AW-1:0]     mem_adr;
  logic [DW-1:0]     mem_wdat;
  logic [BW-1:0]     mem_dqm;
  logic [DW-1:0]     mem_rdat;
  logic [1:0]        dbg_state;

  logic [W-1:0]  exp_q[$];
  logic [DW-1:0] rdat_q[$];
  int            n_vec;
  int            n_fail;
  logic [DW-1:0] last_rd;

  sdram_port_arbiter #(.NCH(NCH), .AW(AW), .DW(DW), .RST_DLY(RST_DLY)) dut (
    .clk(clk), .rst_n(rst_n),
    .wb_stb(wb_stb), .wb_we(wb_we), .wb_sel(wb_sel), .wb_adr(wb_adr), .wb_wdat(wb_wdat),
    .wb_ack(wb_ack), .wb_rdat(wb_rdat),
    .mem_rst_n(mem_rst_n), .mem_ready(mem_ready),
    .mem_wr_req(mem_wr_req), .mem_rd_req(mem_rd_req),
    .mem_wr_ack(mem_wr_ack), .mem_rd_ack(mem_rd_ack),
    .mem_adr(mem_adr), .mem_wdat(mem_wdat), .mem_dqm(mem_dqm), .mem_rdat(mem_rdat),
    .dbg_state(dbg_state)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // driver tasks
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic set_ch(input int ch, input logic we, input logic [BW-1:0] sel,
                        input logic [AW-1:0] adr, input logic [DW-1:0] wdat);
    wb_we[ch]            = we;
    wb_sel[ch*BW +: BW]  = sel;
    wb_adr[ch*AW +: AW]  = adr;
    wb_wdat[ch*DW +: DW] = wdat;
  endtask

  // scoreboard: wait (bounded) for a request, then pop and compare its descriptor
  task automatic wait_req(input string tag);
    logic         got;
    logic [W-1:0] e;
    got = 1'b0;
    for (int i = 0; i < 20 && !got; i++) begin
      if (mem_wr_req | mem_rd_req) got = 1'b1;
      else tick();
    end
    chk({tag, "_seen"}, 64'(got), 64'd1);
    chk({tag, "_onehot"}, 64'(mem_wr_req ^ mem_rd_req), 64'd1);
    e = exp_q.pop_front();
    chk(tag, 64'({mem_wr_req, mem_adr, mem_wdat, mem_dqm}), 64'(e));
  endtask

  task automatic ack_pulse(input logic wr, input logic [DW-1:0] rd);
    if (wr) mem_wr_ack = 1'b1;
    else begin
      mem_rd_ack = 1'b1;
      mem_rdat   = rd;
    end
    tick();
    mem_wr_ack = 1'b0;
    mem_rd_ack = 1'b0;
    mem_rdat   = '0;
  endtask

  task automatic chk_rdat(input string tag);
    logic [DW-1:0] e;
    e = rdat_q.pop_front();
    chk(tag, 64'(wb_rdat), 64'(e));
    last_rd = e;
  endtask

  initial begin
    n_vec = 0; n_fail = 0; last_rd = '0;
    rst_n = 1'b0; mem_ready = 1'b0;
    wb_stb = '0; wb_we = '0; wb_sel = '0; wb_adr = '0; wb_wdat = '0;
    mem_wr_ack = 1'b0; mem_rd_ack = 1'b0; mem_rdat = '0;

    // reset state
    repeat (3) tick();
    chk("rst_mem_rst_n", 64'(mem_rst_n), 64'd0);
    chk("rst_wb_ack", 64'(wb_ack), 64'd0);
    chk("rst_reqs", 64'({mem_wr_req, mem_rd_req}), 64'd0);
    chk("rst_adr", 64'(mem_adr), 64'd0);
    chk("rst_wdat_dqm", 64'({mem_wdat, mem_dqm}), 64'd0);
    chk("rst_rdat", 64'(wb_rdat), 64'd0);
    chk("rst_state", 64'(dbg_state), 64'd0);

    // reset release: first cycle with rst_n=1 is cycle 0, mem_rst_n high in cycle 4
    rst_n = 1'b1;
    for (int c = 1; c <= RST_DLY; c++) begin
      tick();
      chk($sformatf("mem_rst_n_c%0d", c), 64'(mem_rst_n), 64'(c == RST_DLY));
    end

    // single write on ch0
    mem_ready = 1'b1;
    set_ch(0, 1'b1, 2'b10, 21'h1234A, 16'hBEEF);
    wb_stb = 3'b001;
    exp_q.push_back({1'b1, 21'h1234A, 16'hBEEF, 2'b01});
    tick();
    chk("wr_req_latency", 64'(mem_wr_req), 64'd1);
    wait_req("wr0");
    repeat (3) tick();
    chk("wr0_req_held", 64'(mem_wr_req), 64'd1);
    chk("wr0_no_early_ack", 64'(wb_ack), 64'd0);
    ack_pulse(1'b1, '0);
    chk("wr0_ack", 64'(wb_ack), 64'b001);
    chk("wr0_req_drop", 64'(mem_wr_req), 64'd0);
    repeat (2) tick();
    chk("wr0_ack_held", 64'(wb_ack), 64'b001);
    wb_stb = 3'b000;
    #1;
    chk("wr0_ack_fall", 64'(wb_ack), 64'd0);
    tick();

    // read on ch1 with a wrong-type ack during REQ
    set_ch(1, 1'b0, 2'b11, 21'h00010, 16'h1111);
    wb_stb = 3'b010;
    exp_q.push_back({1'b0, 21'h00010, 16'h1111, 2'b00});
    tick();
    chk("rd_req_latency", 64'(mem_rd_req), 64'd1);
    wait_req("rd1");
    mem_wr_ack = 1'b1;
    tick();
    mem_wr_ack = 1'b0;
    tick();
    chk("rd1_wrong_ack_req", 64'(mem_rd_req), 64'd1);
    chk("rd1_wrong_ack_wb", 64'(wb_ack), 64'd0);
    rdat_q.push_back(16'h5A5A);
    ack_pulse(1'b0, 16'h5A5A);
    chk("rd1_ack", 64'(wb_ack), 64'b010);
    chk("rd1_req_drop", 64'(mem_rd_req), 64'd0);
    chk_rdat("rd1_rdat");
    wb_stb = 3'b000;
    tick();

    // round robin after a fresh reset: all strobes high, expect 0,1,2,0
    rst_n = 1'b0;
    tick();
    chk("rr_rst_mem_rst_n", 64'(mem_rst_n), 64'd0);
    rst_n = 1'b1;
    for (int i = 0; i < NCH; i++) set_ch(i, 1'b1, 2'b11, AW'(32'h100 + i), DW'(32'hA000 + i));
    wb_stb = 3'b111;
    for (int n = 0; n < 4; n++) begin
      int ch;
      ch = n % NCH;
      exp_q.push_back({1'b1, AW'(32'h100 + ch), DW'(32'hA000 + ch), 2'b00});
      wait_req($sformatf("rr%0d", n));
      tick();
      ack_pulse(1'b1, '0);
      chk($sformatf("rr%0d_ack", n), 64'(wb_ack), 64'(3'b001 << ch));
      wb_stb[ch] = 1'b0;
      #1;
      chk($sformatf("rr%0d_release", n), 64'(wb_ack), 64'd0);
      tick();
      if (n < 3) wb_stb[ch] = 1'b1;
    end
    wb_stb = 3'b000;
    tick();

    // abort: ch0 drops in REQ, ch1 becomes pending and is served after DRAIN
    set_ch(0, 1'b0, 2'b11, 21'h02000, 16'h0202);
    set_ch(1, 1'b0, 2'b01, 21'h03000, 16'h0303);
    wb_stb = 3'b001;
    exp_q.push_back({1'b0, 21'h02000, 16'h0202, 2'b00});
    wait_req("ab0");
    wb_stb = 3'b010;
    repeat (2) tick();
    chk("ab0_req_held", 64'(mem_rd_req), 64'd1);
    chk("ab0_no_ack", 64'(wb_ack), 64'd0);
    rdat_q.push_back(16'h7777);
    ack_pulse(1'b0, 16'h7777);
    chk("ab0_drain_no_ack", 64'(wb_ack), 64'd0);
    chk("ab0_req_drop", 64'(mem_rd_req), 64'd0);
    chk_rdat("ab0_rdat");
    exp_q.push_back({1'b0, 21'h03000, 16'h0303, 2'b00});
    wait_req("ab1");
    rdat_q.push_back(16'h1357);
    ack_pulse(1'b0, 16'h1357);
    chk("ab1_ack", 64'(wb_ack), 64'b010);
    chk_rdat("ab1_rdat");
    wb_stb = 3'b000;
    tick();

    // not ready: no request while mem_ready=0
    mem_ready = 1'b0;
    set_ch(2, 1'b1, 2'b01, 21'h00055, 16'h55AA);
    wb_stb = 3'b100;
    for (int c = 0; c < 3; c++) begin
      tick();
      chk($sformatf("nr_no_req%0d", c), 64'({mem_wr_req, mem_rd_req}), 64'd0);
    end
    mem_ready = 1'b1;
    exp_q.push_back({1'b1, 21'h00055, 16'h55AA, 2'b10});
    tick();
    chk("nr_req_latency", 64'(mem_wr_req), 64'd1);
    wait_req("nr2");
    ack_pulse(1'b1, '0);
    chk("nr2_ack", 64'(wb_ack), 64'b100);
    chk("nr2_rdat_kept", 64'(wb_rdat), 64'(last_rd));
    wb_stb = 3'b000;
    tick();

    // reset in the middle of a transaction
    set_ch(0, 1'b1, 2'b11, 21'h00077, 16'h7777);
    wb_stb = 3'b001;
    exp_q.push_back({1'b1, 21'h00077, 16'h7777, 2'b00});
    wait_req("mr0");
    rst_n = 1'b0;
    tick();
    chk("mr_reqs", 64'({mem_wr_req, mem_rd_req}), 64'd0);
    chk("mr_wb_ack", 64'(wb_ack), 64'd0);
    chk("mr_mem_rst_n", 64'(mem_rst_n), 64'd0);
    chk("mr_state", 64'(dbg_state), 64'd0);
    chk("mr_rdat", 64'(wb_rdat), 64'd0);
    wb_stb = 3'b000;
    rst_n = 1'b1;
    tick();

    // final report
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule
